// File: rtl/motor_sched_pkg.sv
// Shared definitions for the motor command scheduler.
// Contents: per-slot state encoding and the default parameter values used by
// the top level, its interface and the bench.
package motor_sched_pkg;

    typedef enum logic [1:0] {
        StOff  = 2'd0,
        StRun  = 2'd1,
        StHold = 2'd2,
        StLock = 2'd3
    } slot_state_e;

    localparam int unsigned NumMotorsDef  = 5;
    localparam int unsigned DutyWidthDef  = 10;
    localparam int unsigned SlewStepDef   = 4;
    localparam int unsigned TickDivDef    = 1024;
    localparam int unsigned HoldTicksDef  = 256;
    localparam int unsigned MaxRetriesDef = 3;
    localparam int unsigned CmdAddrWidth  = 3;

endpackage

// File: rtl/motor_cmd_scheduler_if.sv
// Command / driver bus of the motor command scheduler.
// master: command source and fault reporter (drives cmd_*, drv_fault).
// slave : the scheduler (drives drv_en, drv_duty, lockout).
interface motor_cmd_scheduler_if
    import motor_sched_pkg::*;
#(
    parameter int unsigned NUM_MOTORS = NumMotorsDef,
    parameter int unsigned DUTY_WIDTH = DutyWidthDef
);
    logic                             cmd_wr;
    logic [CmdAddrWidth-1:0]          cmd_addr;
    logic                             cmd_en;
    logic [DUTY_WIDTH-1:0]            cmd_duty;
    logic [NUM_MOTORS-1:0]            drv_fault;
    logic [NUM_MOTORS-1:0]            drv_en;
    logic [NUM_MOTORS*DUTY_WIDTH-1:0] drv_duty;
    logic [NUM_MOTORS-1:0]            lockout;

    modport master (
        output cmd_wr, cmd_addr, cmd_en, cmd_duty, drv_fault,
        input  drv_en, drv_duty, lockout
    );

    modport slave (
        input  cmd_wr, cmd_addr, cmd_en, cmd_duty, drv_fault,
        output drv_en, drv_duty, lockout
    );

endinterface

// File: rtl/tick_prescaler.sv
// Free-running prescaler producing a one-cycle tick every DIV clocks.
// Ports: clk, rst_n (async active-low), tick_o (high for one cycle when the
// counter wraps; first tick is sampled DIV rising edges after reset release).
module tick_prescaler #(
    parameter int unsigned DIV = 1024
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] Last = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == Last);

    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + CntW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/motor_cmd_scheduler.sv
// Motor command scheduler: holds a target (enable, duty) per motor slot and,
// once per tick, sweeps the slots through one shared slew/FSM engine.
// Faults and disabling writes act on any cycle; everything else waits for the
// slot's turn in the sweep.
// Ports: clk, rst_n (async active-low), bus (slave modport: command write,
// per-driver fault in; per-driver enable, duty and lockout out, registered).
module motor_cmd_scheduler
    import motor_sched_pkg::*;
#(
    parameter int unsigned NUM_MOTORS  = NumMotorsDef,
    parameter int unsigned DUTY_WIDTH  = DutyWidthDef,
    parameter int unsigned SLEW_STEP   = SlewStepDef,
    parameter int unsigned TICK_DIV    = TickDivDef,
    parameter int unsigned HOLD_TICKS  = HoldTicksDef,
    parameter int unsigned MAX_RETRIES = MaxRetriesDef
) (
    input logic                 clk,
    input logic                 rst_n,
    motor_cmd_scheduler_if.slave bus
);

    localparam int unsigned IdxW   = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1;
    localparam int unsigned RetryW = $clog2(MAX_RETRIES + 1);
    localparam int unsigned HoldW  = $clog2(HOLD_TICKS + 1);

    localparam logic [DUTY_WIDTH-1:0] Step     = DUTY_WIDTH'(SLEW_STEP);
    localparam logic [IdxW-1:0]       LastIdx  = IdxW'(NUM_MOTORS - 1);
    localparam logic [RetryW-1:0]     RetryMax = RetryW'(MAX_RETRIES);
    localparam logic [HoldW-1:0]      HoldInit = HoldW'(HOLD_TICKS);

    typedef logic [DUTY_WIDTH-1:0] duty_t;

    // Moves cur toward tgt by at most Step, landing exactly on tgt.
    function automatic duty_t slew(input duty_t cur, input duty_t tgt);
        if (tgt > cur) begin
            return ((tgt - cur) > Step) ? cur + Step : tgt;
        end else begin
            return ((cur - tgt) > Step) ? cur - Step : tgt;
        end
    endfunction

    slot_state_e       state_q    [NUM_MOTORS];
    slot_state_e       state_d    [NUM_MOTORS];
    logic              tgt_en_q   [NUM_MOTORS];
    logic              tgt_en_d   [NUM_MOTORS];
    duty_t             tgt_duty_q [NUM_MOTORS];
    duty_t             tgt_duty_d [NUM_MOTORS];
    duty_t             duty_q     [NUM_MOTORS];
    duty_t             duty_d     [NUM_MOTORS];
    logic [RetryW-1:0] retry_q    [NUM_MOTORS];
    logic [RetryW-1:0] retry_d    [NUM_MOTORS];
    logic [HoldW-1:0]  hold_q     [NUM_MOTORS];
    logic [HoldW-1:0]  hold_d     [NUM_MOTORS];

    logic            sweep_busy_q, sweep_busy_d;
    logic [IdxW-1:0] sweep_idx_q, sweep_idx_d;
    logic            tick;

    logic [NUM_MOTORS-1:0]            drv_en_q, drv_en_d;
    logic [NUM_MOTORS*DUTY_WIDTH-1:0] drv_duty_q, drv_duty_d;
    logic [NUM_MOTORS-1:0]            lockout_q, lockout_d;

    tick_prescaler #(
        .DIV (TICK_DIV)
    ) u_tick_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_o (tick)
    );

    // Sweep sequencer: one slot per cycle starting the cycle after the tick.
    always_comb begin
        sweep_busy_d = sweep_busy_q;
        sweep_idx_d  = sweep_idx_q;
        if (tick) begin
            sweep_busy_d = 1'b1;
            sweep_idx_d  = '0;
        end else if (sweep_busy_q) begin
            if (sweep_idx_q == LastIdx) begin
                sweep_busy_d = 1'b0;
                sweep_idx_d  = '0;
            end else begin
                sweep_idx_d = sweep_idx_q + IdxW'(1);
            end
        end
    end

    // Next-state: sweep engine first, then disabling write, then fault, so a
    // fault always wins; the target latch is independent of all three.
    always_comb begin
        logic  svc;
        logic  wr;
        duty_t nduty;
        svc   = 1'b0;
        wr    = 1'b0;
        nduty = '0;
        for (int unsigned i = 0; i < NUM_MOTORS; i++) begin
            state_d[i]    = state_q[i];
            tgt_en_d[i]   = tgt_en_q[i];
            tgt_duty_d[i] = tgt_duty_q[i];
            duty_d[i]     = duty_q[i];
            retry_d[i]    = retry_q[i];
            hold_d[i]     = hold_q[i];

            svc = sweep_busy_q && (sweep_idx_q == IdxW'(i));
            // Out-of-range addresses never match a slot, so they are dropped.
            wr  = bus.cmd_wr && (32'(bus.cmd_addr) == i);

            if (svc) begin
                case (state_q[i])
                    StOff: begin
                        if (tgt_en_q[i] && (tgt_duty_q[i] != '0)) begin
                            nduty      = slew('0, tgt_duty_q[i]);
                            state_d[i] = StRun;
                            duty_d[i]  = nduty;
                            if (nduty == tgt_duty_q[i]) retry_d[i] = '0;
                        end
                    end
                    StRun: begin
                        if ((duty_q[i] == '0) && (tgt_duty_q[i] == '0)) begin
                            state_d[i] = StOff;
                        end else begin
                            nduty     = slew(duty_q[i], tgt_duty_q[i]);
                            duty_d[i] = nduty;
                            if ((nduty == tgt_duty_q[i]) && (tgt_duty_q[i] != '0)) begin
                                retry_d[i] = '0;
                            end
                        end
                    end
                    StHold: begin
                        if (hold_q[i] <= HoldW'(1)) begin
                            hold_d[i]  = '0;
                            state_d[i] = (retry_q[i] == RetryMax) ? StLock : StOff;
                        end else begin
                            hold_d[i] = hold_q[i] - HoldW'(1);
                        end
                    end
                    default: ;
                endcase
            end

            if (wr && !bus.cmd_en) begin
                if ((state_q[i] == StRun) || (state_q[i] == StHold)) begin
                    state_d[i] = StOff;
                    duty_d[i]  = '0;
                    hold_d[i]  = '0;
                end else if (state_q[i] == StLock) begin
                    state_d[i] = StOff;
                    retry_d[i] = '0;
                end
            end

            if (bus.drv_fault[i] && (state_q[i] == StRun)) begin
                state_d[i] = StHold;
                duty_d[i]  = '0;
                retry_d[i] = retry_q[i] + RetryW'(1);
                hold_d[i]  = HoldInit;
            end

            if (wr) begin
                tgt_en_d[i]   = bus.cmd_en;
                tgt_duty_d[i] = bus.cmd_duty;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_MOTORS; i++) begin
                state_q[i]    <= StOff;
                tgt_en_q[i]   <= 1'b0;
                tgt_duty_q[i] <= '0;
                duty_q[i]     <= '0;
                retry_q[i]    <= '0;
                hold_q[i]     <= '0;
            end
            sweep_busy_q <= 1'b0;
            sweep_idx_q  <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_MOTORS; i++) begin
                state_q[i]    <= state_d[i];
                tgt_en_q[i]   <= tgt_en_d[i];
                tgt_duty_q[i] <= tgt_duty_d[i];
                duty_q[i]     <= duty_d[i];
                retry_q[i]    <= retry_d[i];
                hold_q[i]     <= hold_d[i];
            end
            sweep_busy_q <= sweep_busy_d;
            sweep_idx_q  <= sweep_idx_d;
        end
    end

    // Outputs decode the registered state and are registered once more.
    always_comb begin
        drv_en_d   = '0;
        drv_duty_d = '0;
        lockout_d  = '0;
        for (int unsigned i = 0; i < NUM_MOTORS; i++) begin
            drv_en_d[i]  = (state_q[i] == StRun);
            lockout_d[i] = (state_q[i] == StLock);
            drv_duty_d[i*DUTY_WIDTH +: DUTY_WIDTH] = (state_q[i] == StRun) ? duty_q[i] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drv_en_q   <= '0;
            drv_duty_q <= '0;
            lockout_q  <= '0;
        end else begin
            drv_en_q   <= drv_en_d;
            drv_duty_q <= drv_duty_d;
            lockout_q  <= lockout_d;
        end
    end

    assign bus.drv_en   = drv_en_q;
    assign bus.drv_duty = drv_duty_q;
    assign bus.lockout  = lockout_q;

endmodule

// File: tb/tb_motor_cmd_scheduler.sv
// Directed bench for motor_cmd_scheduler with TICK_DIV=16, HOLD_TICKS=2.
// Slot i's outputs change on the rising edge numbered 16k+2+i after reset
// release (tick seen on edge 16k, slot i serviced on edge 16k+1+i).
module tb_motor_cmd_scheduler;

    localparam int unsigned NM = 5;
    localparam int unsigned DW = 10;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;

    motor_cmd_scheduler_if #(.NUM_MOTORS(NM), .DUTY_WIDTH(DW)) bus ();

    motor_cmd_scheduler #(
        .NUM_MOTORS  (NM),
        .DUTY_WIDTH  (DW),
        .SLEW_STEP   (4),
        .TICK_DIV    (16),
        .HOLD_TICKS  (2),
        .MAX_RETRIES (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [DW-1:0] duty_of(input int unsigned s);
        return bus.drv_duty[s*DW +: DW];
    endfunction

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.cmd_wr    = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_en    = 1'b0;
        bus.cmd_duty  = '0;
        bus.drv_fault = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Applies inputs for one clock starting at the current falling edge.
    task automatic drive(input logic wr, input logic [2:0] addr, input logic en,
                         input logic [DW-1:0] duty, input logic [NM-1:0] fault);
        bus.cmd_wr    = wr;
        bus.cmd_addr  = addr;
        bus.cmd_en    = en;
        bus.cmd_duty  = duty;
        bus.drv_fault = fault;
        @(negedge clk);
        bus.cmd_wr    = 1'b0;
        bus.drv_fault = '0;
    endtask

    // Advances to the falling edge right after slot s's next output update.
    task automatic wait_slot(input int unsigned s);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(cyc >= 16 && (cyc % 16) == int'(s) + 2) && n < 64);
        if (n >= 64) begin
            checks++;
            errors++;
            $display("FAIL wait_slot%0d timeout cyc=%0d", s, cyc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.cmd_wr = 1'b0;
        bus.drv_fault = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.drv_en !== '0 || bus.drv_duty !== '0 || bus.lockout !== '0) begin
            errors++;
            $display("FAIL reset_in en=%h duty=%h lock=%h want 0", bus.drv_en, bus.drv_duty,
                     bus.lockout);
        end
        do_reset();
        repeat (10) @(negedge clk);
        checks++;
        if (bus.drv_en !== '0 || bus.drv_duty !== '0 || bus.lockout !== '0) begin
            errors++;
            $display("FAIL reset_after en=%h duty=%h lock=%h want 0", bus.drv_en, bus.drv_duty,
                     bus.lockout);
        end
    endtask

    task automatic test_ramp_up();
        int unsigned exp_d [4] = '{4, 8, 10, 10};
        do_reset();
        drive(1'b1, 3'd1, 1'b1, 10'd10, '0);
        for (int k = 0; k < 4; k++) begin
            wait_slot(1);
            checks++;
            if (bus.drv_en[1] !== 1'b1 || duty_of(1) !== exp_d[k]) begin
                errors++;
                $display("FAIL ramp_up tick%0d en=%b duty=%0d want en=1 duty=%0d", k,
                         bus.drv_en[1], duty_of(1), exp_d[k]);
            end
        end
    endtask

    task automatic test_ramp_down();
        int unsigned up_d [5] = '{4, 8, 12, 16, 20};
        int unsigned dn_d [5] = '{16, 12, 8, 4, 0};
        do_reset();
        drive(1'b1, 3'd0, 1'b1, 10'd20, '0);
        for (int k = 0; k < 5; k++) begin
            wait_slot(0);
            checks++;
            if (duty_of(0) !== up_d[k]) begin
                errors++;
                $display("FAIL ramp_down_up tick%0d duty=%0d want %0d", k, duty_of(0), up_d[k]);
            end
        end
        drive(1'b1, 3'd0, 1'b1, 10'd0, '0);
        for (int k = 0; k < 5; k++) begin
            wait_slot(0);
            checks++;
            if (bus.drv_en[0] !== 1'b1 || duty_of(0) !== dn_d[k]) begin
                errors++;
                $display("FAIL ramp_down tick%0d en=%b duty=%0d want en=1 duty=%0d", k,
                         bus.drv_en[0], duty_of(0), dn_d[k]);
            end
        end
        wait_slot(0);
        checks++;
        if (bus.drv_en[0] !== 1'b0 || duty_of(0) !== 10'd0) begin
            errors++;
            $display("FAIL ramp_down_off en=%b duty=%0d want en=0 duty=0", bus.drv_en[0],
                     duty_of(0));
        end
    endtask

    task automatic test_fault();
        do_reset();
        drive(1'b1, 3'd2, 1'b1, 10'd10, '0);
        wait_slot(2);
        drive(1'b0, 3'd0, 1'b0, 10'd0, 5'b00100);
        @(negedge clk);
        checks++;
        if (bus.drv_en[2] !== 1'b0 || duty_of(2) !== 10'd0) begin
            errors++;
            $display("FAIL fault_off en=%b duty=%0d want en=0 duty=0", bus.drv_en[2], duty_of(2));
        end
        for (int k = 0; k < 2; k++) begin
            wait_slot(2);
            checks++;
            if (bus.drv_en[2] !== 1'b0) begin
                errors++;
                $display("FAIL fault_hold tick%0d en=%b want 0", k, bus.drv_en[2]);
            end
        end
        wait_slot(2);
        checks++;
        if (bus.drv_en[2] !== 1'b1 || duty_of(2) !== 10'd4) begin
            errors++;
            $display("FAIL fault_reramp en=%b duty=%0d want en=1 duty=4", bus.drv_en[2],
                     duty_of(2));
        end
    endtask

    task automatic test_lockout();
        do_reset();
        drive(1'b1, 3'd2, 1'b1, 10'd10, '0);
        for (int it = 0; it < 3; it++) begin
            wait_slot(2);
            checks++;
            if (bus.drv_en[2] !== 1'b1 || duty_of(2) !== 10'd4 || bus.lockout[2] !== 1'b0) begin
                errors++;
                $display("FAIL lock_run it%0d en=%b duty=%0d lock=%b want 1/4/0", it,
                         bus.drv_en[2], duty_of(2), bus.lockout[2]);
            end
            drive(1'b0, 3'd0, 1'b0, 10'd0, 5'b00100);
            wait_slot(2);
            wait_slot(2);
            checks++;
            if (bus.drv_en[2] !== 1'b0 || bus.lockout[2] !== (it == 2)) begin
                errors++;
                $display("FAIL lock_hold it%0d en=%b lock=%b want en=0 lock=%b", it,
                         bus.drv_en[2], bus.lockout[2], (it == 2));
            end
        end
        wait_slot(2);
        checks++;
        if (bus.lockout[2] !== 1'b1 || bus.drv_en[2] !== 1'b0) begin
            errors++;
            $display("FAIL lock_stay lock=%b en=%b want 1/0", bus.lockout[2], bus.drv_en[2]);
        end
        drive(1'b1, 3'd2, 1'b0, 10'd10, '0);
        @(negedge clk);
        checks++;
        if (bus.lockout[2] !== 1'b0) begin
            errors++;
            $display("FAIL lock_clear lock=%b want 0", bus.lockout[2]);
        end
        drive(1'b1, 3'd2, 1'b1, 10'd10, '0);
        wait_slot(2);
        checks++;
        if (bus.drv_en[2] !== 1'b1 || duty_of(2) !== 10'd4) begin
            errors++;
            $display("FAIL lock_rerun en=%b duty=%0d want 1/4", bus.drv_en[2], duty_of(2));
        end
    endtask

    task automatic test_addr_collision();
        int unsigned exp_d [4] = '{4, 8, 12, 16};
        do_reset();
        drive(1'b1, 3'd7, 1'b1, 10'd100, '0);
        drive(1'b1, 3'd5, 1'b1, 10'd100, '0);
        wait_slot(4);
        checks++;
        if (bus.drv_en !== '0 || bus.drv_duty !== '0) begin
            errors++;
            $display("FAIL bad_addr en=%h duty=%h want 0", bus.drv_en, bus.drv_duty);
        end
        drive(1'b1, 3'd3, 1'b1, 10'd8, '0);
        wait_slot(3);
        drive(1'b1, 3'd3, 1'b1, 10'd20, 5'b01000);
        @(negedge clk);
        checks++;
        if (bus.drv_en[3] !== 1'b0) begin
            errors++;
            $display("FAIL collide_hold en=%b want 0", bus.drv_en[3]);
        end
        wait_slot(3);
        wait_slot(3);
        for (int k = 0; k < 4; k++) begin
            wait_slot(3);
            checks++;
            if (bus.drv_en[3] !== 1'b1 || duty_of(3) !== exp_d[k]) begin
                errors++;
                $display("FAIL collide_ramp tick%0d en=%b duty=%0d want en=1 duty=%0d", k,
                         bus.drv_en[3], duty_of(3), exp_d[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        drive(1'b1, 3'd1, 1'b1, 10'd40, '0);
        wait_slot(1);
        wait_slot(1);
        checks++;
        if (duty_of(1) !== 10'd8) begin
            errors++;
            $display("FAIL mid_pre duty=%0d want 8", duty_of(1));
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.drv_en !== '0 || bus.drv_duty !== '0 || bus.lockout !== '0) begin
            errors++;
            $display("FAIL mid_reset en=%h duty=%h lock=%h want 0", bus.drv_en, bus.drv_duty,
                     bus.lockout);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 3'd1, 1'b1, 10'd40, '0);
        n = 0;
        while (cyc < 18 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cyc != 18 || bus.drv_en[1] !== 1'b0) begin
            errors++;
            $display("FAIL mid_early cyc=%0d en=%b want cyc=18 en=0", cyc, bus.drv_en[1]);
        end
        @(negedge clk);
        checks++;
        if (bus.drv_en[1] !== 1'b1 || duty_of(1) !== 10'd4) begin
            errors++;
            $display("FAIL mid_first_tick en=%b duty=%0d want en=1 duty=4", bus.drv_en[1],
                     duty_of(1));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_fault();
        test_lockout();
        test_addr_collision();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
